// File: rtl/wb_ram_slave_pkg.sv
// Shared Wishbone cycle/burst type codes and small decode helpers for the
// RAM responder and its burst address generator.
package wb_ram_slave_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   localparam int WAIT_CNT_W = 4;

   // Only incrementing bursts are served as bursts; every other code,
   // including reserved ones, falls back to a classic single access.
   function automatic logic cti_is_burst(input logic [2:0] cti);
      case (cti)
         CTI_INCR:                        return 1'b1;
         CTI_CLASSIC, CTI_CONST, CTI_EOB: return 1'b0;
         default:                         return 1'b0;
      endcase
   endfunction

   // Word-address bits that rotate inside a wrap burst; zero for linear.
   function automatic logic [3:0] bte_wrap_mask(input logic [1:0] bte);
      case (bte)
         BTE_WRAP4:  return 4'h3;
         BTE_WRAP8:  return 4'h7;
         BTE_WRAP16: return 4'hF;
         default:    return 4'h0;
      endcase
   endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next word address for an incrementing burst. Linear bursts carry into the
// extra top bit so the caller can see the window being overrun; wrap bursts
// only rotate the low 2/3/4 bits and never leave their aligned block.
module wb_burst_addr_gen
   import wb_ram_slave_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic [AW-1:0] cur_idx_i,
   input  logic [1:0]    bte_i,
   output logic [AW:0]   nxt_idx_o
);

   logic [AW:0] cur_ext;
   logic [AW:0] inc;
   logic [AW:0] mask;

   // Increment, then keep the upper bits for wrapping burst types.
   always_comb begin
      cur_ext = {1'b0, cur_idx_i};
      inc     = cur_ext + {{AW{1'b0}}, 1'b1};
      mask    = {{(AW-3){1'b0}}, bte_wrap_mask(bte_i)};
      if (bte_i == BTE_LINEAR) begin
         nxt_idx_o = inc;
      end else begin
         nxt_idx_o = (cur_ext & ~mask) | (inc & mask);
      end
   end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B3 responder in front of a word-addressed on-chip RAM.
// Classic cycles with a fixed wait-state count, registered-feedback
// incrementing bursts (linear, wrap-4/8/16), ERR on out-of-window access.
//
//   state          | meaning
//   ---------------+---------------------------------------------------------
//   ST_IDLE        | no access in progress, waiting for cyc & stb
//   ST_WAIT        | counting wait states before the first ack
//   ST_CLASSIC_ACK | single-cycle ack of a classic access, write on this edge
//   ST_BURST       | one ack per cycle while stb is high, address advances
//   ST_ERROR       | one-cycle err, no memory access
module wb_ram_slave
   import wb_ram_slave_pkg::*;
#(
   parameter int                       ADDRESS_WIDTH = 32,
   parameter int                       DATA_WIDTH    = 32,
   parameter int                       MEM_WORDS     = 1024,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int                       WAIT_STATES   = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [ADDRESS_WIDTH-1:0] wbs_adr_i,
   input  logic [DATA_WIDTH-1:0]    wbs_dat_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic                     wbs_we_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   input  logic [2:0]               wbs_cti_i,
   input  logic [1:0]               wbs_bte_i,
   output logic [DATA_WIDTH-1:0]    wbs_dat_o,
   output logic                     wbs_ack_o,
   output logic                     wbs_err_o,
   output logic                     wbs_rty_o
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [ADDRESS_WIDTH-1:0] RANGE_BYTES = ADDRESS_WIDTH'(4 * MEM_WORDS);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CLASSIC_ACK,
      ST_BURST,
      ST_ERROR
   } state_e;

   state_e                  state_q,    state_d;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [AW-1:0]           idx_q,      idx_d;
   logic                    burst_q,    burst_d;
   logic                    ack_q,      ack_d;
   logic                    err_q,      err_d;
   logic [DATA_WIDTH-1:0]   dat_q,      dat_d;

   logic [DATA_WIDTH-1:0]   ram_q [MEM_WORDS];
   logic                    ram_we;
   logic [AW-1:0]           ram_widx;

   logic [ADDRESS_WIDTH-1:0] adr_off;
   logic                     adr_in_range;
   logic [AW-1:0]            adr_idx;
   logic [AW:0]              nxt_idx;
   logic                     unused_adr;

   // An address below the base wraps the subtraction to a large offset,
   // so a single compare covers both window edges.
   assign adr_off      = wbs_adr_i - BASE_ADDR;
   assign adr_in_range = (adr_off < RANGE_BYTES);
   assign adr_idx      = adr_off[AW+1:2];
   assign unused_adr   = ^{adr_off[ADDRESS_WIDTH-1:AW+2], adr_off[1:0]};

   wb_burst_addr_gen #(
      .AW (AW)
   ) u_addr_gen (
      .cur_idx_i (idx_q),
      .bte_i     (wbs_bte_i),
      .nxt_idx_o (nxt_idx)
   );

   // Registered ack/err qualified by the live bus so a master stall or an
   // abandoned cycle never sees a stale termination.
   assign wbs_ack_o = ack_q & wbs_cyc_i & wbs_stb_i;
   assign wbs_err_o = err_q & wbs_cyc_i;
   assign wbs_rty_o = 1'b0;
   assign wbs_dat_o = dat_q;

   // Next-state, termination and RAM write decode.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      idx_d      = idx_q;
      burst_d    = burst_q;
      ack_d      = ack_q;
      err_d      = 1'b0;
      dat_d      = dat_q;
      ram_we     = 1'b0;
      ram_widx   = idx_q;

      if (!wbs_cyc_i) begin
         state_d    = ST_IDLE;
         ack_d      = 1'b0;
         wait_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (wbs_stb_i) begin
                  idx_d   = adr_idx;
                  burst_d = cti_is_burst(wbs_cti_i);
                  if (!adr_in_range) begin
                     state_d = ST_ERROR;
                     err_d   = 1'b1;
                  end else if (WAIT_STATES > 0) begin
                     state_d    = ST_WAIT;
                     wait_cnt_d = WAIT_LOAD;
                  end else begin
                     state_d = cti_is_burst(wbs_cti_i) ? ST_BURST : ST_CLASSIC_ACK;
                     ack_d   = 1'b1;
                     dat_d   = ram_q[adr_idx];
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt_q == '0) begin
                  state_d = burst_q ? ST_BURST : ST_CLASSIC_ACK;
                  ack_d   = 1'b1;
                  dat_d   = ram_q[idx_q];
               end else begin
                  wait_cnt_d = wait_cnt_q - 1'b1;
               end
            end
            ST_CLASSIC_ACK: begin
               ram_we  = wbs_ack_o & wbs_we_i;
               state_d = ST_IDLE;
               ack_d   = 1'b0;
            end
            ST_BURST: begin
               if (wbs_ack_o) begin
                  ram_we = wbs_we_i;
                  if (wbs_cti_i == CTI_EOB) begin
                     state_d = ST_IDLE;
                     ack_d   = 1'b0;
                  end else if (nxt_idx[AW]) begin
                     // Linear burst ran off the top of the window: the
                     // following beat is terminated with err instead.
                     state_d = ST_ERROR;
                     ack_d   = 1'b0;
                     err_d   = 1'b1;
                  end else begin
                     // Prefetch the next beat so acks come back to back.
                     idx_d = nxt_idx[AW-1:0];
                     dat_d = ram_q[nxt_idx[AW-1:0]];
                  end
               end
            end
            ST_ERROR: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               ack_d   = 1'b0;
            end
         endcase
      end
   end

   // Control and output registers; async reset drops ack/err immediately.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         idx_q      <= '0;
         burst_q    <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         dat_q      <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         idx_q      <= idx_d;
         burst_q    <= burst_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         dat_q      <= dat_d;
      end
   end

   // Byte-lane RAM write; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
               ram_q[ram_widx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end
         end
      end
   end

   // Ack and err are built to be mutually exclusive.
   assert property (@(posedge clk_i) disable iff (!rst_i) !(ack_q && err_q));

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Wishbone B3 responder (slave) backing an on-chip word-addressed RAM, the target end of the CPU instruction/data master buses in the SoC template. Serves classic single cycles with a configurable wait-state count and registered-feedback incrementing bursts (linear and wrap-4/8/16). Raises ERR for out-of-range addresses and drives RTY low.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width (fixed 4 byte lanes)
- MEM_WORDS, 1024, RAM depth in words (power of two)
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window
- WAIT_STATES, 1, extra cycles before first ACK of any access (0..15)
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-low reset
- wbs_adr_i  in  ADDRESS_WIDTH  byte address, bits [1:0] ignored
- wbs_dat_i  in  DATA_WIDTH  write data
- wbs_sel_i  in  4  byte lane selects (writes only)
- wbs_we_i  in  1  write enable
- wbs_stb_i  in  1  strobe
- wbs_cyc_i  in  1  bus cycle
- wbs_cti_i  in  3  cycle type identifier
- wbs_bte_i  in  2  burst type extension
- wbs_dat_o  out  DATA_WIDTH  read data, valid only while wbs_ack_o=1
- wbs_ack_o  out  1  acknowledge
- wbs_err_o  out  1  error termination
- wbs_rty_o  out  1  retry, constant 0

## Operation
- In range: BASE_ADDR <= adr < BASE_ADDR+4*MEM_WORDS; word index = (adr-BASE_ADDR)>>2.
- States: IDLE, WAIT, CLASSIC_ACK, BURST, ERROR.
- IDLE: cyc&stb sampled -> out of range: ERROR; else WAIT (WAIT_STATES>0) or ack state directly. CTI 010 selects BURST; all other CTI (000, 001, 111, reserved) treated as classic.
- WAIT: count WAIT_STATES cycles, then CLASSIC_ACK or BURST.
- CLASSIC_ACK: ack_o high exactly one cycle; write performed on that edge for lanes with sel=1; -> IDLE.
- BURST: ack_o = ack_q & cyc_i & stb_i; each acked beat reads/writes current address, internal address advances per BTE: 00 linear +4; 01/10/11 wrap low 2/3/4 word-address bits (4/8/16 beats). Beat with CTI=111 is last: acked, then -> IDLE. Next address out of range on a linear burst: that beat gets err_o instead of ack, -> IDLE.
- ERROR: err_o high one cycle, no memory access, -> IDLE.
- Master stall (stb_i low, cyc_i high) in BURST: no ack, address holds, state holds.
- cyc_i low in any state: -> IDLE next cycle, no ack/err, no write performed.
- Reads return full word regardless of sel.
- Reset: state IDLE, ack_o=0, err_o=0, rty_o=0, dat_o=0, counters 0. RAM contents not reset.

## Timing
- Classic: stb sampled cycle n -> ack_o in n+1+WAIT_STATES; min 2 cycles per classic access (ack low cycle after ack).
- Burst: first ack at n+1+WAIT_STATES, then one beat per cycle while stb_i high; read data prefetched for next address so no bubbles.
- err_o at n+1 (no wait states on error path).
- ack_o and err_o never high together; never high with cyc_i low.
- rst_i assertion mid-transfer: outputs 0 immediately (asynchronous), no partial write.

## Structure
- Shared include (wb_soc_includes.vh): CTI_CLASSIC 3'b000, CTI_CONST 3'b001, CTI_INCR 3'b010, CTI_EOB 3'b111; BTE_LINEAR 2'b00, BTE_WRAP4 2'b01, BTE_WRAP8 2'b10, BTE_WRAP16 2'b11.
- State encoding local to the module.
- One sub-module: wb_burst_addr_gen (current word address + BTE -> next word address, combinational).
- RAM as an inferred reg array with per-byte write enables.

## Test plan
- WAIT_STATES=1: classic write 0xDEADBEEF to 0x10, sel 1111, then read 0x10 -> each ack 2 cycles after stb, single-cycle ack, read returns 0xDEADBEEF.
- Word 0x20 = 0x11223344; write 0x00AA0000 sel 0100 -> read 0x20 returns 0x11AA3344.
- Preload 0x40..0x4C with 1,2,3,4; linear burst read of 4 (CTI 010,010,010,111) -> acks on 4 consecutive cycles, data 1,2,3,4, ack low afterwards.
- Wrap-4 read burst starting 0x38 -> beats served from 0x38,0x3C,0x30,0x34.
- Read/write to BASE_ADDR+4*MEM_WORDS -> err_o high one cycle at n+1, ack_o never, RAM unchanged.
- 4-beat write burst, cyc_i dropped after beat 2 (repeat with rst_i low after beat 2) -> beats 1-2 written, beats 3-4 not, ack_o/err_o 0 on following cycle.
